// File: rtl/dma_arb_sys.sv
// Single-channel memory-to-memory DMA with a register slave, sharing one fabric
// port with an external CPU through a registered two-master arbiter (CPU wins ties).
module dma_arb_sys #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        dma_req,
  input  logic        m0_req,
  input  logic        m0_lock,
  output logic        m0_grant,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  output logic [31:0] addr_f,
  output logic [31:0] wd_f,
  output logic        we_f,
  output logic [3:0]  byte_en,
  input  logic [31:0] rd_m,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_line_en, r_inc_src, r_inc_dst, r_done;
  logic [1:0]        r_src_size, r_dst_size;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_src, r_dst, r_item;
  logic [1:0]        r_grant, w_grant_nxt;

  logic              w_busy, w_dma_breq, w_dma_we;
  logic [31:0]       w_dma_addr, w_dma_wd, w_item;
  logic [3:0]        w_dma_be;
  logic [15:0]       w_cnt16;
  logic [31:0]       w_rd_byte, w_rd_half;
  logic              w_unused_bits;

  // Lane enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   f_be = 4'b0001 << a;
      2'b01:   f_be = 4'b0011 << {a[1], 1'b0};
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_step(input logic [1:0] size);
    case (size)
      2'b00:   f_step = 32'd1;
      2'b01:   f_step = 32'd2;
      default: f_step = 32'd4;
    endcase
  endfunction

  assign w_busy        = (r_state != S_IDLE);
  assign w_dma_breq    = (r_state == S_REQ) || (r_state == S_READ) || (r_state == S_WRITE);
  assign w_cnt16       = 16'(r_cnt);
  assign w_unused_bits = &{1'b0, wd[15:7]};
  assign dbg_state     = r_state;
  assign m0_grant      = r_grant[0];

  assign w_rd_byte = rd_m >> {r_src[1:0], 3'b000};
  assign w_rd_half = rd_m >> {r_src[1], 4'b0000};

  always_comb begin
    case (r_src_size)
      2'b00:   w_item = {24'b0, w_rd_byte[7:0]};
      2'b01:   w_item = {16'b0, w_rd_half[15:0]};
      default: w_item = rd_m;
    endcase
  end

  always_comb begin
    case (addr)
      4'h0:    rd = {w_cnt16, 9'b0, r_dst_size, r_src_size, r_inc_dst, r_inc_src, r_line_en};
      4'h4:    rd = r_src;
      4'h8:    rd = r_dst;
      4'hC:    rd = {30'b0, r_done, w_busy};
      default: rd = 32'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dma_addr  = 32'b0;
    w_dma_wd    = 32'b0;
    w_dma_we    = 1'b0;
    w_dma_be    = 4'b1111;
    case (r_state)
      S_IDLE: begin
        if (r_line_en && (r_cnt != '0) && dma_req) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (r_grant[1]) w_state_nxt = S_READ;
      end
      S_READ: begin
        w_dma_addr  = r_src;
        w_dma_be    = f_be(r_src_size, r_src[1:0]);
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_dma_addr = r_dst;
        w_dma_we   = 1'b1;
        w_dma_be   = f_be(r_dst_size, r_dst[1:0]);
        case (r_dst_size)
          2'b00:   w_dma_wd = {4{r_item[7:0]}};
          2'b01:   w_dma_wd = {2{r_item[15:0]}};
          default: w_dma_wd = r_item;
        endcase
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register slave plus datapath progress; the FSM updates come last so they win.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_line_en  <= 1'b0;
      r_inc_src  <= 1'b0;
      r_inc_dst  <= 1'b0;
      r_src_size <= 2'b00;
      r_dst_size <= 2'b00;
      r_cnt      <= '0;
      r_src      <= 32'b0;
      r_dst      <= 32'b0;
      r_done     <= 1'b0;
      r_item     <= 32'b0;
    end else begin
      if (we && (addr == 4'h0)) r_done <= 1'b0;
      if (we && !w_busy) begin
        case (addr)
          4'h0: begin
            r_line_en  <= wd[0];
            r_inc_src  <= wd[1];
            r_inc_dst  <= wd[2];
            r_src_size <= wd[4:3];
            r_dst_size <= wd[6:5];
            r_cnt      <= wd[16 +: CNT_W];
          end
          4'h4:    r_src <= wd;
          4'h8:    r_dst <= wd;
          default: ;
        endcase
      end else if (we && (addr == 4'h0) && !wd[0]) begin
        r_line_en <= 1'b0;
      end
      if (r_state == S_READ) r_item <= w_item;
      if (r_state == S_WRITE) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_inc_src) r_src <= r_src + f_step(r_src_size);
        if (r_inc_dst) r_dst <= r_dst + f_step(r_dst_size);
      end
      if ((r_state == S_GAP) && (r_cnt == '0)) begin
        r_line_en <= 1'b0;
        r_done    <= 1'b1;
      end
    end
  end

  // Owner keeps the bus while its req or lock is high; release costs one idle cycle.
  always_comb begin
    w_grant_nxt = r_grant;
    if (r_grant == 2'b00) begin
      if (m0_req)          w_grant_nxt = 2'b01;
      else if (w_dma_breq) w_grant_nxt = 2'b10;
    end else if (r_grant[0] && !(m0_req || m0_lock)) begin
      w_grant_nxt = 2'b00;
    end else if (r_grant[1] && !w_dma_breq) begin
      w_grant_nxt = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_grant <= 2'b00;
    end else begin
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    addr_f  = 32'b0;
    wd_f    = 32'b0;
    we_f    = 1'b0;
    byte_en = 4'b1111;
    if (r_grant[0]) begin
      addr_f = m0_addr;
      wd_f   = m0_wd;
      we_f   = m0_we;
    end else if (r_grant[1]) begin
      addr_f  = w_dma_addr;
      wd_f    = w_dma_wd;
      we_f    = w_dma_we;
      byte_en = w_dma_be;
    end
  end

endmodule

// File: tb/tb_dma_arb_sys.sv
// Directed bench for dma_arb_sys: reset, programming, word and byte transfers,
// CPU/DMA contention, abort, zero count and reset in the middle of a beat.
module tb_dma_arb_sys;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        dma_req;
  logic        m0_req, m0_lock, m0_we;
  logic        m0_grant;
  logic [31:0] m0_addr, m0_wd;
  logic [31:0] addr_f, wd_f;
  logic        we_f;
  logic [3:0]  byte_en;
  logic [31:0] rd_m;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_REQ   = 32'd1;
  localparam logic [31:0] ST_READ  = 32'd2;
  localparam logic [31:0] ST_WRITE = 32'd3;

  dma_arb_sys #(.CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .we(we), .wd(wd), .rd(rd),
    .dma_req(dma_req), .m0_req(m0_req), .m0_lock(m0_lock), .m0_grant(m0_grant),
    .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we),
    .addr_f(addr_f), .wd_f(wd_f), .we_f(we_f), .byte_en(byte_en),
    .rd_m(rd_m), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    rstn = 1'b1; addr = 4'h0; we = 1'b0; wd = 32'h0; dma_req = 1'b0;
    m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wd = 32'h0;
    rd_m = 32'h0;

    // reset held for 7 cycles
    ticks(7);
    rchk("rst_cr", 4'h0, 32'h0);
    rchk("rst_src", 4'h4, 32'h0);
    rchk("rst_dst", 4'h8, 32'h0);
    rchk("rst_sr", 4'hC, 32'h0);
    chk("rst_grant", 32'(m0_grant), 32'h0);
    chk("rst_addr_f", addr_f, 32'h0);
    chk("rst_we_f", 32'(we_f), 32'h0);
    chk("rst_be", 32'(byte_en), 32'hF);
    chk("rst_state", 32'(dbg_state), ST_IDLE);
    rstn = 1'b0;
    tick();

    // programmed but no dma_req: nothing moves
    wr(4'h0, 32'h0002_0053);
    wr(4'h4, 32'h0000_0010);
    wr(4'h8, 32'h0001_0110);
    wr(4'h2, 32'hFFFF_FFFF);
    ticks(3);
    chk("idle_we_f", 32'(we_f), 32'h0);
    chk("idle_addr_f", addr_f, 32'h0);
    chk("idle_state", 32'(dbg_state), ST_IDLE);
    rchk("prog_cr", 4'h0, 32'h0002_0053);
    rchk("prog_src", 4'h4, 32'h0000_0010);
    rchk("prog_dst", 4'h8, 32'h0001_0110);
    rchk("prog_sr", 4'hC, 32'h0);
    rchk("unmapped", 4'h2, 32'h0);

    // two word beats, source increments, destination fixed
    exp_q.push_back(32'h0000_0010);
    exp_q.push_back(32'h0000_0014);
    rd_m = 32'hA5A5_0001;
    dma_req = 1'b1;
    ticks(3);
    for (int b = 0; b < 2; b++) begin
      chk("w_rd_state", 32'(dbg_state), ST_READ);
      chk("w_rd_addr", addr_f, exp_q.pop_front());
      chk("w_rd_we", 32'(we_f), 32'h0);
      chk("w_rd_be", 32'(byte_en), 32'hF);
      rchk("w_busy", 4'hC, 32'h1);
      tick();
      chk("w_wr_addr", addr_f, 32'h0001_0110);
      chk("w_wr_we", 32'(we_f), 32'h1);
      chk("w_wr_data", wd_f, 32'hA5A5_0001);
      chk("w_wr_be", 32'(byte_en), 32'hF);
      tick();
      if (b == 0) begin
        rchk("w_mid_cr", 4'h0, 32'h0001_0053);
        rchk("w_mid_src", 4'h4, 32'h0000_0014);
      end
      tick();
      if (b == 0) ticks(3);
    end
    chk("w_end_state", 32'(dbg_state), ST_IDLE);
    rchk("w_end_cr", 4'h0, 32'h0000_0052);
    rchk("w_end_sr", 4'hC, 32'h2);
    rchk("w_end_src", 4'h4, 32'h0000_0018);
    rchk("w_end_dst", 4'h8, 32'h0001_0110);
    chk("w_q_empty", 32'(exp_q.size()), 32'h0);
    dma_req = 1'b0;

    // byte mode: lane 2 of source to lane 1 of destination
    rd_m = 32'h00CC_0000;
    wr(4'h4, 32'h0000_0002);
    wr(4'h8, 32'h0000_0101);
    wr(4'h0, 32'h0001_0003);
    rchk("b_done_clr", 4'hC, 32'h0);
    dma_req = 1'b1;
    ticks(3);
    chk("b_rd_addr", addr_f, 32'h0000_0002);
    chk("b_rd_be", 32'(byte_en), 32'h4);
    tick();
    chk("b_wr_addr", addr_f, 32'h0000_0101);
    chk("b_wr_data", wd_f, 32'hCCCC_CCCC);
    chk("b_wr_be", 32'(byte_en), 32'h2);
    ticks(2);
    rchk("b_src", 4'h4, 32'h0000_0003);
    rchk("b_dst", 4'h8, 32'h0000_0101);
    rchk("b_sr", 4'hC, 32'h2);
    rchk("b_cr", 4'h0, 32'h0000_0002);
    dma_req = 1'b0;

    // contention: CPU and DMA both requesting, CPU wins
    rd_m = 32'h0;
    wr(4'h4, 32'h0000_0100);
    wr(4'h8, 32'h0000_0200);
    wr(4'h0, 32'h0001_0051);
    dma_req = 1'b1;
    tick();
    m0_req = 1'b1; m0_addr = 32'h0000_1234; m0_wd = 32'hDEAD_BEEF; m0_we = 1'b1;
    tick();
    chk("c_m0_grant", 32'(m0_grant), 32'h1);
    chk("c_m0_addr", addr_f, 32'h0000_1234);
    chk("c_m0_wd", wd_f, 32'hDEAD_BEEF);
    chk("c_m0_we", 32'(we_f), 32'h1);
    chk("c_dma_wait", 32'(dbg_state), ST_REQ);
    tick();
    m0_req = 1'b0; m0_lock = 1'b1;
    tick();
    chk("c_lock_hold", 32'(m0_grant), 32'h1);
    m0_lock = 1'b0; m0_we = 1'b0;
    tick();
    chk("c_rel_grant", 32'(m0_grant), 32'h0);
    chk("c_rel_addr", addr_f, 32'h0);
    chk("c_rel_state", 32'(dbg_state), ST_REQ);
    tick();
    chk("c_dma_gnt_state", 32'(dbg_state), ST_REQ);
    chk("c_dma_gnt_addr", addr_f, 32'h0);
    tick();
    chk("c_dma_read", 32'(dbg_state), ST_READ);
    chk("c_dma_raddr", addr_f, 32'h0000_0100);
    dma_req = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0000_5678;
    tick();
    chk("c_no_steal", 32'(m0_grant), 32'h0);
    chk("c_dma_waddr", addr_f, 32'h0000_0200);
    ticks(2);
    chk("c_idle_gap", 32'(m0_grant), 32'h0);
    tick();
    chk("c_m0_regrant", 32'(m0_grant), 32'h1);
    chk("c_m0_addr2", addr_f, 32'h0000_5678);
    m0_req = 1'b0;
    tick();
    rchk("c_sr", 4'hC, 32'h2);

    // abort during beat 1 of three
    wr(4'h4, 32'h0000_0300);
    wr(4'h8, 32'h0000_0400);
    wr(4'h0, 32'h0003_0057);
    dma_req = 1'b1;
    ticks(3);
    chk("a_read", 32'(dbg_state), ST_READ);
    wr(4'h0, 32'h0);
    chk("a_write", 32'(dbg_state), ST_WRITE);
    ticks(3);
    chk("a_idle", 32'(dbg_state), ST_IDLE);
    rchk("a_cr", 4'h0, 32'h0002_0056);
    rchk("a_sr", 4'hC, 32'h0);
    rchk("a_src", 4'h4, 32'h0000_0304);
    rchk("a_dst", 4'h8, 32'h0000_0404);

    // enabled with zero count: nothing starts, done stays clear
    wr(4'h0, 32'h0000_0051);
    ticks(4);
    chk("z_state", 32'(dbg_state), ST_IDLE);
    chk("z_we_f", 32'(we_f), 32'h0);
    rchk("z_sr", 4'hC, 32'h0);

    // reset in the middle of a beat
    wr(4'h0, 32'h0001_0051);
    ticks(3);
    chk("r_read", 32'(dbg_state), ST_READ);
    rstn = 1'b1;
    #1;
    chk("r_state", 32'(dbg_state), ST_IDLE);
    chk("r_addr_f", addr_f, 32'h0);
    rchk("r_cr", 4'h0, 32'h0);
    rchk("r_src", 4'h4, 32'h0);
    rstn = 1'b0;
    dma_req = 1'b0;
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
